serial_tx_sched: RTL and testbench

- Byte-slot scheduler and controller for the lane's parallel-to-serial transmitter, running in the clk_32f domain.
- Divides clk_32f into 8-cycle byte slots and picks the byte for each slot: a COM sync symbol, an IDLE symbol, or a user data byte.
- Drives the serializer's parallel load, the IDL indication and a ready/valid handshake toward the upstream byte source.
- Sits between the byte-striping logic and the parallel-to-serial converter.

---
 rtl/serial_tx_pkg.sv | 9 +
 rtl/serial_tx_sched_if.sv | 28 ++
 rtl/serial_tx_sched_slot_timer.sv | 32 +++
 rtl/serial_tx_sched.sv | 92 +++++++++
 tb/tb_serial_tx_sched.sv | 134 +++++++++++++
 5 files changed

// File: rtl/serial_tx_pkg.sv
// serial_tx_pkg: shared symbols, slot length and FSM encoding for the serial transmit scheduler
package serial_tx_pkg;
    localparam logic [7:0] COM_SYM  = 8'hBC;
    localparam logic [7:0] IDLE_SYM = 8'h7C;
    localparam int SYNC_BYTES_DEF   = 4;
    localparam int SLOT_LEN         = 8;
    localparam int CNT_W            = $clog2(SLOT_LEN);
    typedef enum logic [1:0] {SYNC = 2'd0, IDLE = 2'd1, XFER = 2'd2} state_t;
endpackage

// File: rtl/serial_tx_sched_if.sv
// serial_tx_sched_if: upstream byte handshake and serializer-facing outputs (tx_count only with SERIAL_TX_BYTE_CNT_EN)
interface serial_tx_sched_if;
    logic       active;
    logic [7:0] data_in;
    logic       valid_in;
    logic       ready;
    logic [7:0] data_out;
    logic       load;
    logic       IDL;
    logic [1:0] state_out;
`ifdef SERIAL_TX_BYTE_CNT_EN
    logic [15:0] tx_count;
`endif
    modport master (
        output active, data_in, valid_in,
        input  ready, data_out, load, IDL, state_out
`ifdef SERIAL_TX_BYTE_CNT_EN
        , tx_count
`endif
    );
    modport slave (
        input  active, data_in, valid_in,
        output ready, data_out, load, IDL, state_out
`ifdef SERIAL_TX_BYTE_CNT_EN
        , tx_count
`endif
    );
endinterface

// File: rtl/serial_tx_sched_slot_timer.sv
// slot_timer: 8-cycle byte slot counter; load_phase is a flop so it stays low in the first slot after reset
module slot_timer
    import serial_tx_pkg::*;
(
    input  logic clk_32f,
    input  logic reset,
    output logic slot_edge,
    output logic load_phase
);
    logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;
    logic             load_phase_q, load_phase_d;

    assign slot_edge  = bit_cnt_q == CNT_W'(SLOT_LEN - 1);
    assign load_phase = load_phase_q;

    // free-running wrap counter; load follows the slot edge by one cycle
    always_comb begin
        bit_cnt_d    = bit_cnt_q + 1'b1;
        load_phase_d = slot_edge;
    end

    // slot state flops
    always_ff @(posedge clk_32f or posedge reset) begin
        if (reset) begin
            bit_cnt_q    <= '0;
            load_phase_q <= 1'b0;
        end else begin
            bit_cnt_q    <= bit_cnt_d;
            load_phase_q <= load_phase_d;
        end
    end
endmodule

// File: rtl/serial_tx_sched.sv
// serial_tx_sched: per-slot COM/IDLE/data byte selection and upstream handshake; SERIAL_TX_BYTE_CNT_EN adds a saturating tx_count
module serial_tx_sched #(
    parameter logic [7:0] COM_SYM    = serial_tx_pkg::COM_SYM,
    parameter logic [7:0] IDLE_SYM   = serial_tx_pkg::IDLE_SYM,
    parameter int         SYNC_BYTES = serial_tx_pkg::SYNC_BYTES_DEF
) (
    input logic              clk_32f,
    input logic              reset,
    serial_tx_sched_if.slave bus
);
    import serial_tx_pkg::*;

    logic       slot_edge, load_phase, xfer, last_sync;
    state_t     state_q, state_d;
    logic [3:0] sync_cnt_q, sync_cnt_d;
    logic [7:0] data_q, data_d;
    logic       idl_q, idl_d;

    slot_timer u_slot_timer (
        .clk_32f   (clk_32f),
        .reset     (reset),
        .slot_edge (slot_edge),
        .load_phase(load_phase)
    );

    assign bus.ready     = slot_edge && (state_q == IDLE || state_q == XFER) && bus.active;
    assign xfer          = bus.ready && bus.valid_in;
    assign last_sync     = sync_cnt_q == 4'(SYNC_BYTES - 1);
    assign bus.data_out  = data_q;
    assign bus.load      = load_phase;
    assign bus.IDL       = idl_q;
    assign bus.state_out = state_q;

    // slot-edge decision: anything but an active IDLE/XFER (or finished SYNC) falls back to sending COM in SYNC
    always_comb begin
        state_d    = state_q;
        sync_cnt_d = sync_cnt_q;
        data_d     = data_q;
        idl_d      = idl_q;
        if (slot_edge) begin
            state_d    = SYNC;
            sync_cnt_d = '0;
            data_d     = COM_SYM;
            idl_d      = 1'b1;
            case (state_q)
                SYNC: if (bus.active) begin
                    state_d    = last_sync ? IDLE : SYNC;
                    sync_cnt_d = last_sync ? 4'd0 : sync_cnt_q + 4'd1;
                end
                IDLE, XFER: if (bus.active) begin
                    state_d = xfer ? XFER : IDLE;
                    data_d  = xfer ? bus.data_in : IDLE_SYM;
                    idl_d   = !xfer;
                end
                default: ;
            endcase
        end
    end

    // FSM and registered outputs
    always_ff @(posedge clk_32f or posedge reset) begin
        if (reset) begin
            state_q    <= SYNC;
            sync_cnt_q <= '0;
            data_q     <= 8'h00;
            idl_q      <= 1'b1;
        end else begin
            state_q    <= state_d;
            sync_cnt_q <= sync_cnt_d;
            data_q     <= data_d;
            idl_q      <= idl_d;
        end
    end

`ifdef SERIAL_TX_BYTE_CNT_EN
    logic [15:0] tx_count_q, tx_count_d;

    assign bus.tx_count = tx_count_q;

    // accepted-byte counter, saturating, cleared whenever the link falls back into SYNC
    always_comb begin
        tx_count_d = (slot_edge && state_d == SYNC && state_q != SYNC) ? 16'h0000 :
                     (xfer && tx_count_q != 16'hFFFF) ? tx_count_q + 16'd1 : tx_count_q;
    end

    // counter flop
    always_ff @(posedge clk_32f or posedge reset) begin
        if (reset) tx_count_q <= '0;
        else       tx_count_q <= tx_count_d;
    end
`endif
endmodule

// File: tb/tb_serial_tx_sched.sv
// tb_serial_tx_sched: slot-aligned stimulus with a scoreboard of expected loaded bytes
module tb_serial_tx_sched;
    logic clk_32f = 1'b0;
    logic reset   = 1'b1;
    int   checks  = 0;
    int   errors  = 0;
    logic [8:0] sb[$];

    always #5 clk_32f = ~clk_32f;

    serial_tx_sched_if bus();

    serial_tx_sched dut (
        .clk_32f(clk_32f),
        .reset  (reset),
        .bus    (bus)
    );

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
        end
    endtask

    // every load must match the oldest expected {IDL, byte}
    always @(negedge clk_32f) begin : mon
        logic [8:0] e;
        if (bus.load === 1'b1) begin
            if (sb.size() == 0) check("load_unexpected", 32'd1, 32'd0);
            else begin
                e = sb.pop_front();
                check("load_data", bus.data_out, e[7:0]);
                check("load_idl", bus.IDL, e[8]);
            end
        end
    end

    // one 8-cycle slot starting at bit_cnt==0; mv raises valid_in mid-slot
    task automatic slot(input logic [7:0] d, input logic idl, input logic [1:0] st,
                        input logic rdy, input logic mv);
        sb.push_back({idl, d});
        repeat (3) @(posedge clk_32f);
        @(negedge clk_32f);
        check("ready_mid", bus.ready, 32'd0);
        if (mv) begin
            bus.valid_in = 1'b1;
            #1;
            check("ready_mid_valid", bus.ready, 32'd0);
        end
        repeat (4) @(posedge clk_32f);
        @(negedge clk_32f);
        check("ready_edge", bus.ready, rdy);
        @(negedge clk_32f);
        #1;
        check("state", bus.state_out, st);
        check("sb_pop", sb.size(), 32'd0);
    endtask

    task automatic check_reset_vals();
        check("rst_data", bus.data_out, 32'h00);
        check("rst_load", bus.load, 32'd0);
        check("rst_idl", bus.IDL, 32'd1);
        check("rst_state", bus.state_out, 32'd0);
        check("rst_ready", bus.ready, 32'd0);
`ifdef SERIAL_TX_BYTE_CNT_EN
        check("rst_count", bus.tx_count, 32'd0);
`endif
    endtask

    initial begin
        bus.active   = 1'b0;
        bus.valid_in = 1'b0;
        bus.data_in  = 8'h00;
        repeat (2) @(negedge clk_32f);
        check_reset_vals();
        reset = 1'b0;
        // link disabled: only COM, never ready
        for (int i = 0; i < 5; i++) slot(8'hBC, 1'b1, 2'd0, 1'b0, 1'b0);
        // sync sequence then idle fill
        bus.active = 1'b1;
        for (int i = 0; i < 3; i++) slot(8'hBC, 1'b1, 2'd0, 1'b0, 1'b0);
        slot(8'hBC, 1'b1, 2'd1, 1'b0, 1'b0);
        for (int i = 0; i < 2; i++) slot(8'h7C, 1'b1, 2'd1, 1'b1, 1'b0);
        // back-to-back data
        bus.valid_in = 1'b1;
        bus.data_in  = 8'hA5; slot(8'hA5, 1'b0, 2'd2, 1'b1, 1'b0);
        bus.data_in  = 8'h3C; slot(8'h3C, 1'b0, 2'd2, 1'b1, 1'b0);
        bus.data_in  = 8'hFF; slot(8'hFF, 1'b0, 2'd2, 1'b1, 1'b0);
`ifdef SERIAL_TX_BYTE_CNT_EN
        check("count3", bus.tx_count, 32'd3);
`endif
        bus.valid_in = 1'b0;
        slot(8'h7C, 1'b1, 2'd1, 1'b1, 1'b0);
        // valid raised mid-slot is taken only at the slot edge
        bus.data_in = 8'h5A;
        slot(8'h5A, 1'b0, 2'd2, 1'b1, 1'b1);
        bus.valid_in = 1'b0;
        slot(8'h7C, 1'b1, 2'd1, 1'b1, 1'b0);
        // drop active during XFER with data pending
        bus.valid_in = 1'b1;
        bus.data_in  = 8'h11; slot(8'h11, 1'b0, 2'd2, 1'b1, 1'b0);
`ifdef SERIAL_TX_BYTE_CNT_EN
        check("count5", bus.tx_count, 32'd5);
`endif
        bus.active  = 1'b0;
        bus.data_in = 8'h22; slot(8'hBC, 1'b1, 2'd0, 1'b0, 1'b0);
`ifdef SERIAL_TX_BYTE_CNT_EN
        check("count_sync_clr", bus.tx_count, 32'd0);
`endif
        bus.valid_in = 1'b0;
        bus.active   = 1'b1;
        for (int i = 0; i < 3; i++) slot(8'hBC, 1'b1, 2'd0, 1'b0, 1'b0);
        slot(8'hBC, 1'b1, 2'd1, 1'b0, 1'b0);
        slot(8'h7C, 1'b1, 2'd1, 1'b1, 1'b0);
        // reset in the middle of an XFER slot
        bus.valid_in = 1'b1;
        bus.data_in  = 8'h33; slot(8'h33, 1'b0, 2'd2, 1'b1, 1'b0);
        bus.data_in  = 8'h44;
        repeat (4) @(posedge clk_32f);
        @(negedge clk_32f);
        reset = 1'b1;
        #1;
        check_reset_vals();
        repeat (2) @(negedge clk_32f);
        reset        = 1'b0;
        bus.valid_in = 1'b0;
        slot(8'hBC, 1'b1, 2'd0, 1'b0, 1'b0);
        check("sb_drain", sb.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
